// File: rtl/soft_tbm_trg_sched_if.sv
// Software command port and event output bundle of the soft TBM trigger scheduler.
interface soft_tbm_trg_sched_if;
    logic       sw_valid;
    logic [4:0] sw_cmd;
    logic       sw_ready;
    logic [4:0] trg_out;
    logic [3:0] trg_pos;

    modport master (output sw_valid, sw_cmd, input sw_ready, trg_out, trg_pos);
    modport slave  (input sw_valid, sw_cmd, output sw_ready, trg_out, trg_pos);
endinterface

// File: rtl/soft_tbm_trg_sched.sv
// Trigger scheduler: arbitrates software, external and periodic events into one
// event vector per sync slot, enforcing a minimum gap and an optional cal->trg follow-up.
module soft_tbm_trg_sched #(
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync,
    input  logic                 enable,
    input  logic [CNTW-1:0]      period,
    input  logic [7:0]           cal_trg_delay,
    input  logic [7:0]           min_gap,
    input  logic                 ext_trg,
    soft_tbm_trg_sched_if.slave  bus,
    output logic                 busy,
    output logic [CNTW-1:0]      lost_count
);

    typedef enum logic [1:0] {IDLE, CALW, GAP} state_t;

    state_t          state, state_nx;
    logic [7:0]      cnt, cnt_nx;
    logic            sw_pend, ext_pend, per_pend, ext_q;
    logic [4:0]      sw_buf;
    logic [CNTW-1:0] per_cnt;
    logic [4:0]      trg_p1;
    logic [3:0]      pos_p1;

    logic            emit;
    logic [4:0]      emit_vec;
    logic [3:0]      emit_pos;
    logic            take_sw, take_ext, take_per;
    logic            sw_acc, ext_edge, ext_lost, per_fire, per_lost;
    logic [1:0]      lost_inc;

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] acc,
                                                input logic [1:0] inc);
        logic [CNTW:0] sum;
        sum = {1'b0, acc} + {{(CNTW-1){1'b0}}, inc};
        return sum[CNTW] ? {CNTW{1'b1}} : sum[CNTW-1:0];
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        emit     = 1'b0;
        emit_vec = 5'd0;
        emit_pos = 4'd0;
        take_sw  = 1'b0;
        take_ext = 1'b0;
        take_per = 1'b0;
        case (state)
            IDLE: begin
                if (sw_pend) begin
                    emit = 1'b1; emit_vec = sw_buf;   emit_pos = 4'd1; take_sw = 1'b1;
                end else if (ext_pend) begin
                    emit = 1'b1; emit_vec = 5'b00010; emit_pos = 4'd2; take_ext = 1'b1;
                end else if (per_pend) begin
                    emit = 1'b1; emit_vec = 5'b00010; emit_pos = 4'd3; take_per = 1'b1;
                end
                if (emit) begin
                    if (emit_vec[4] && cal_trg_delay != 8'd0) begin
                        state_nx = CALW;
                        cnt_nx   = cal_trg_delay;
                    end else if (min_gap != 8'd0) begin
                        state_nx = GAP;
                        cnt_nx   = min_gap;
                    end
                end
            end
            CALW: begin
                if (cnt <= 8'd1) begin
                    emit     = 1'b1;
                    emit_vec = 5'b00010;
                    emit_pos = 4'd4;
                    if (min_gap != 8'd0) begin
                        state_nx = GAP;
                        cnt_nx   = min_gap;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            GAP: begin
                if (cnt <= 8'd1) state_nx = IDLE;
                else             cnt_nx   = cnt - 8'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A request arriving while its flag is being consumed keeps the flag set and is not lost.
    assign sw_acc   = bus.sw_valid && !sw_pend && (bus.sw_cmd != 5'd0);
    assign ext_edge = ext_trg && !ext_q;
    assign ext_lost = enable && ext_edge && ext_pend && !take_ext;
    assign per_fire = enable && (period != '0) && (per_cnt == '0);
    assign per_lost = per_fire && per_pend && !take_per;
    assign lost_inc = {1'b0, ext_lost} + {1'b0, per_lost};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            sw_pend    <= 1'b0;
            ext_pend   <= 1'b0;
            per_pend   <= 1'b0;
            ext_q      <= 1'b0;
            per_cnt    <= '0;
            trg_p1     <= 5'd0;
            pos_p1     <= 4'd0;
            lost_count <= '0;
        end else if (sync) begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            trg_p1 <= emit ? emit_vec : 5'd0;
            pos_p1 <= emit ? emit_pos : 4'd0;
            ext_q  <= ext_trg;

            if (take_sw)     sw_pend <= 1'b0;
            else if (sw_acc) sw_pend <= 1'b1;

            if (!enable)       ext_pend <= 1'b0;
            else if (ext_edge) ext_pend <= 1'b1;
            else if (take_ext) ext_pend <= 1'b0;

            if (!enable || period == '0) per_cnt <= '0;
            else if (per_cnt == '0)      per_cnt <= period - 1'b1;
            else                         per_cnt <= per_cnt - 1'b1;

            if (!enable)       per_pend <= 1'b0;
            else if (per_fire) per_pend <= 1'b1;
            else if (take_per) per_pend <= 1'b0;

            lost_count <= sat_add(lost_count, lost_inc);
        end
    end

    // Command payload is only meaningful while sw_pend is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (sync && sw_acc) sw_buf <= bus.sw_cmd;
    end

    assign bus.sw_ready = !sw_pend;
    assign bus.trg_out  = trg_p1;
    assign bus.trg_pos  = pos_p1;
    assign busy         = (state != IDLE) || sw_pend || ext_pend || per_pend;

endmodule

// File: doc/soft_tbm_trg_sched.md
Name: soft_tbm_trg_sched

Overview:
- Trigger scheduler in front of the soft TBM event inputs.
- Arbitrates three event sources: software command port, external trigger input, internal periodic generator.
- Emits one 5-bit event vector per sync slot, in {cal, rst, rsr, trg, syn} bit order (bit0 syn … bit4 cal), plus a 4-bit source tag.
- Enforces a minimum gap between events and optionally follows each cal with an automatic trigger after a programmable delay.

Parameters:
CNTW, 16, width of period counter and lost-trigger counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sync  in  1  clock enable; all state advances only on clk edges with sync=1
enable  in  1  gates external and periodic sources (software path always active)
period  in  CNTW  periodic trigger interval in sync cycles; 0 = periodic off
cal_trg_delay  in  8  sync cycles from cal to its automatic trg; 0 = no auto trg
min_gap  in  8  idle sync cycles forced after every emitted event
ext_trg  in  1  external trigger level, rising edge detected on sync cycles
sw_valid  in  1  software command valid
sw_cmd  in  5  software event vector, same bit order as trg_out
sw_ready  out  1  software slot free
trg_out  out  5  event vector to TBM, nonzero for exactly one sync cycle
trg_pos  out  4  source tag accompanying trg_out
busy  out  1  FSM not in IDLE or any pending flag set
lost_count  out  CNTW  ext/periodic triggers dropped, saturating

Behaviour:
- Reset values: trg_out=0, trg_pos=0, sw_ready=1, busy=0, lost_count=0; FSM=IDLE; all pending flags 0; periodic counter and ext edge register 0. Async reset mid-sequence aborts everything, no partial event.
- Every register updates only when sync=1; with sync=0 everything holds, trg_out included.
- trg_out/trg_pos are registered; a value loaded on sync cycle N is cleared to 0 on sync cycle N+1.
- Software port: one-entry buffer; sw_ready = !sw_pend. sw_valid&&sw_ready&&sync with sw_cmd!=0 sets sw_pend and stores sw_cmd. sw_cmd=0 is ignored.
- External: edge = ext_trg && !ext_q (ext_q sampled each sync). If enable, edge sets ext_pend. If ext_pend is already set, lost_count increments instead.
- Periodic: if enable && period!=0, counter decrements each sync cycle. On reaching 0 (or on the first cycle after enable/period change from 0), counter reloads period-1 and sets per_pend. If per_pend is already set, lost_count increments.
- enable=0 clears ext_pend and per_pend and zeroes the counter.
- ext and periodic loss in the same cycle count +2. lost_count saturates at all-ones.
- FSM states: IDLE, CALW, GAP.
- IDLE, priority sw_pend > ext_pend > per_pend; highest pending source is emitted, its flag is cleared:
  - sw: trg_out=sw_cmd, trg_pos=1
  - ext: trg_out=5'b00010, trg_pos=2
  - periodic: trg_out=5'b00010, trg_pos=3
- After emitting from IDLE:
  - If emitted vector has cal (bit4) and cal_trg_delay!=0: load delay counter = cal_trg_delay, go to CALW.
  - Else, if min_gap!=0: load gap counter = min_gap, go to GAP.
  - Else stay in IDLE; back-to-back emission on consecutive sync cycles is allowed.
- CALW: decrement each sync. On reaching 1, emit trg_out=5'b00010, trg_pos=4, then go to GAP (or IDLE if min_gap=0). Pending sources accumulate meanwhile.
- GAP: decrement each sync; at 1, return to IDLE. No emission in CALW/GAP except the auto trg.
- A pending flag set and consumed in the same sync cycle: consume wins, the new request is held (flag remains 1).
- Latency from an accepted request in IDLE (min_gap=0): trg_out nonzero on the next sync cycle.
- busy = (FSM!=IDLE) || sw_pend || ext_pend || per_pend.

Test Plan:
- Reset, then sw_cmd=5'b00010 with min_gap=0 -> trg_out=00010, trg_pos=1 for exactly one sync cycle one cycle later; sw_ready low for one cycle.
- period=10, enable=1, 50 sync cycles -> 5 triggers tag 3 spaced exactly 10 sync cycles; lost_count=0.
- sw cal (5'b10000), cal_trg_delay=5, min_gap=3 -> cal at N, auto trg tag 4 at N+5, next event no earlier than N+9.
- min_gap=20, period=4, ext edges every 6 cycles -> ext outranks periodic in IDLE; lost_count rises monotonically and matches scoreboard.
- sync toggling 1-in-4 -> identical event sequence in sync-cycle time as with sync=1.
- reset asserted during CALW -> outputs 0 immediately, no auto trg after release.
